mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Consumer of the EX/MEM pipeline register outputs in the pipelined MIPS datapath.
- Resolves the branch decision in MEM.
- Drives a handshaked data-memory port for lw/sw and stalls upstream until the memory acknowledges.
- Registers the result into MEM/WB outputs for writeback.

Parameters:
- DATA_W, 32, datapath and memory word width
- REG_AW, 5, register-file address width
- MEM_TIMEOUT, 15, max WAIT cycles without dmem_ack before abort

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- valid_in  in  1  EX/MEM holds a real instruction
- Branch, MemRead, MemtoReg, MemWrite, RegWrite, zero  in  1 each  EX/MEM control/flag outputs
- write_address  in  REG_AW  destination register
- aluresult  in  DATA_W  ALU result / memory address
- read_out2  in  DATA_W  store data
- incinst  in  DATA_W  branch target address
- stall  out  1  upstream (EX/MEM and earlier) must hold while 1
- pc_src  out  1  take branch
- branch_target  out  DATA_W  = incinst
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  DATA_W  word address
- dmem_wdata  out  DATA_W  store data
- dmem_rdata  in  DATA_W  load data, valid with dmem_ack
- dmem_ack  in  1  one-cycle completion pulse
- wb_valid, RegWriteOut, MemtoRegOut  out  1 each  MEM/WB controls
- write_addressOut  out  REG_AW  MEM/WB destination
- read_dataOut, aluresultOut  out  DATA_W  MEM/WB data
- mem_err  out  1  sticky error flag

Behaviour:
- Clock: single clock clk. Reset: rst_n synchronous, active-low.
- Reset state:
  - state=IDLE, timeout counter=0.
  - All registered outputs 0, including dmem_req, all MEM/WB outputs and mem_err.
- States: IDLE and WAIT.
- memop = valid_in & (MemRead | MemWrite).
- IDLE, valid_in=0:
  - MEM/WB loads a bubble: wb_valid=0, RegWriteOut=0, other MEM/WB outputs unchanged.
- IDLE, valid_in=1, memop=0:
  - Pass-through, latency 1: wb_valid=1 and RegWrite/MemtoReg/write_address/aluresult copied; read_dataOut=0.
- IDLE, memop=1, aluresult[1:0]!=0 (misaligned):
  - No request is issued; completes in 1 cycle.
  - wb_valid=1, RegWriteOut forced 0, mem_err set.
- IDLE, memop=1, aligned:
  - Capture aluresult, read_out2 and the we bit into hold registers; go to WAIT; MEM/WB loads a bubble.
  - If MemRead=MemWrite=1, the access is a write.
- WAIT:
  - dmem_req=1; dmem_we/addr/wdata come from the hold registers and stay stable until ack.
  - Counter increments each cycle.
- WAIT, dmem_ack=1:
  - MEM/WB loads captured controls, wb_valid=1.
  - read_dataOut = dmem_rdata for a read, 0 for a write.
  - State goes to IDLE and dmem_req drops on the next edge.
- WAIT, counter reaches MEM_TIMEOUT with no ack:
  - Go to IDLE, wb_valid=1, RegWriteOut=0, mem_err set.
- stall (combinational) = (IDLE & memop & aligned) | (WAIT & ~dmem_ack & ~timeout).
  - stall drops in the ack cycle, so upstream advances on that same edge.
- Load-to-use latency: 1 cycle after ack.
- pc_src (combinational) = IDLE & valid_in & Branch & zero. It is never asserted in WAIT.
- branch_target = incinst, always.
- dmem_ack is ignored in IDLE.
- mem_err clears only on reset.
- Reset mid-WAIT: the access is abandoned; dmem_req is 0 after that edge and no writeback occurs.

Decomposition:
- Shared package mem_stage_pkg holds:
  - state enum {IDLE, WAIT}
  - default MEM_TIMEOUT
  - DATA_W and REG_AW constants
- One sub-module, mem_wb_register: MEM/WB flops with a load input and a bubble input (clears wb_valid and RegWriteOut).
- The FSM, hold registers and timeout counter stay in the top level.

Test Plan:
- R-type pass-through: valid_in=1, RegWrite=1, aluresult=0x0000_0042, write_address=5 -> next cycle wb_valid=1, aluresultOut=0x42, write_addressOut=5, stall=0 throughout.
- Load, ack 3 cycles after dmem_req: MemRead=1, aluresult=0x100 -> dmem_req=1, dmem_addr=0x100, we=0.
  - Ack cycle carries dmem_rdata=0xDEADBEEF.
  - Required: stall high from accept through the cycle before ack; next edge read_dataOut=0xDEADBEEF, MemtoRegOut=1, wb_valid=1.
- Store, ack on first WAIT cycle: MemWrite=1, aluresult=0x200, read_out2=0x1234 -> dmem_we=1, dmem_wdata=0x1234 for one cycle; wb_valid=1, read_dataOut=0.
- Branch: Branch=1, zero=1, incinst=0x40 -> same cycle pc_src=1, branch_target=0x40.
  - With zero=0 -> pc_src=0.
- Timeout: load, dmem_ack held 0 -> after MEM_TIMEOUT=15 WAIT cycles the FSM returns to IDLE with mem_err=1, RegWriteOut=0, wb_valid=1.
  - Misaligned aluresult=0x102 -> no dmem_req, mem_err=1.
- Reset mid-WAIT: rst_n=0 for 1 cycle during WAIT -> next cycle dmem_req=0, state IDLE, all outputs 0.
  - A late dmem_ack is ignored.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and default sizes for the MEM pipeline stage.
package mem_stage_pkg;

  localparam int DATA_W              = 32;
  localparam int REG_AW              = 5;
  localparam int MEM_TIMEOUT_DEFAULT = 15;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register: load captures a full writeback, bubble kills it.
module mem_wb_register #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              bubble,
  input  logic              valid_d,
  input  logic              reg_write_d,
  input  logic              memto_reg_d,
  input  logic [REG_AW-1:0] write_address_d,
  input  logic [DATA_W-1:0] read_data_d,
  input  logic [DATA_W-1:0] aluresult_d,
  output logic              wb_valid,
  output logic              reg_write,
  output logic              memto_reg,
  output logic [REG_AW-1:0] write_address,
  output logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] aluresult
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid      <= 1'b0;
      reg_write     <= 1'b0;
      memto_reg     <= 1'b0;
      write_address <= '0;
      read_data     <= '0;
      aluresult     <= '0;
    end else if (bubble) begin
      // A bubble only needs to suppress the register-file write.
      wb_valid  <= 1'b0;
      reg_write <= 1'b0;
    end else if (load) begin
      wb_valid      <= valid_d;
      reg_write     <= reg_write_d;
      memto_reg     <= memto_reg_d;
      write_address <= write_address_d;
      read_data     <= read_data_d;
      aluresult     <= aluresult_d;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: branch resolution, handshaked data-memory access with timeout,
// and the MEM/WB pipeline register.
module mem_access_stage #(
  parameter int DATA_W      = mem_stage_pkg::DATA_W,
  parameter int REG_AW      = mem_stage_pkg::REG_AW,
  parameter int MEM_TIMEOUT = mem_stage_pkg::MEM_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic              Branch,
  input  logic              MemRead,
  input  logic              MemtoReg,
  input  logic              MemWrite,
  input  logic              RegWrite,
  input  logic              zero,
  input  logic [REG_AW-1:0] write_address,
  input  logic [DATA_W-1:0] aluresult,
  input  logic [DATA_W-1:0] read_out2,
  input  logic [DATA_W-1:0] incinst,
  output logic              stall,
  output logic              pc_src,
  output logic [DATA_W-1:0] branch_target,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              wb_valid,
  output logic              RegWriteOut,
  output logic              MemtoRegOut,
  output logic [REG_AW-1:0] write_addressOut,
  output logic [DATA_W-1:0] read_dataOut,
  output logic [DATA_W-1:0] aluresultOut,
  output logic              mem_err
);

  import mem_stage_pkg::*;

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic               hold_we_reg, hold_rw_reg, hold_m2r_reg;
  logic [REG_AW-1:0]  hold_wa_reg;
  logic [DATA_W-1:0]  hold_addr_reg, hold_wdata_reg;
  logic               mem_err_reg;

  logic               memop, aligned, accept, timeout, err_set;
  logic               wb_load, wb_bubble, d_rw, d_m2r;
  logic [REG_AW-1:0]  d_wa;
  logic [DATA_W-1:0]  d_rd, d_alu;

  assign memop   = valid_in & (MemRead | MemWrite);
  assign aligned = (aluresult[1:0] == 2'b00);
  assign accept  = (state_reg == IDLE) & memop & aligned;
  // Timeout fires on the MEM_TIMEOUT-th WAIT cycle; an ack in that cycle wins.
  assign timeout = (state_reg == WAIT) & ~dmem_ack & (cnt_reg == CNT_W'(MEM_TIMEOUT - 1));

  assign pc_src        = (state_reg == IDLE) & valid_in & Branch & zero;
  assign branch_target = incinst;
  assign dmem_req      = (state_reg == WAIT);
  assign dmem_we       = hold_we_reg;
  assign dmem_addr     = hold_addr_reg;
  assign dmem_wdata    = hold_wdata_reg;
  assign mem_err       = mem_err_reg;

  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    wb_load    = 1'b0;
    wb_bubble  = 1'b0;
    err_set    = 1'b0;
    d_rw       = RegWrite;
    d_m2r      = MemtoReg;
    d_wa       = write_address;
    d_rd       = '0;
    d_alu      = aluresult;
    case (state_reg)
      IDLE: begin
        if (!valid_in) begin
          wb_bubble = 1'b1;
        end else if (!memop) begin
          wb_load = 1'b1;
        end else if (!aligned) begin
          wb_load = 1'b1;
          d_rw    = 1'b0;
          err_set = 1'b1;
        end else begin
          wb_bubble  = 1'b1;
          stall      = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        d_rw  = hold_rw_reg;
        d_m2r = hold_m2r_reg;
        d_wa  = hold_wa_reg;
        d_alu = hold_addr_reg;
        if (dmem_ack) begin
          wb_load    = 1'b1;
          d_rd       = hold_we_reg ? '0 : dmem_rdata;
          state_next = IDLE;
        end else if (timeout) begin
          wb_load    = 1'b1;
          d_rw       = 1'b0;
          err_set    = 1'b1;
          state_next = IDLE;
        end else begin
          wb_bubble = 1'b1;
          stall     = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      hold_we_reg    <= 1'b0;
      hold_rw_reg    <= 1'b0;
      hold_m2r_reg   <= 1'b0;
      hold_wa_reg    <= '0;
      hold_addr_reg  <= '0;
      hold_wdata_reg <= '0;
      mem_err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= (state_reg == WAIT && state_next == WAIT) ? cnt_reg + 1'b1 : '0;
      if (accept) begin
        hold_we_reg    <= MemWrite;
        hold_rw_reg    <= RegWrite;
        hold_m2r_reg   <= MemtoReg;
        hold_wa_reg    <= write_address;
        hold_addr_reg  <= aluresult;
        hold_wdata_reg <= read_out2;
      end
      if (err_set) mem_err_reg <= 1'b1;
    end
  end

  mem_wb_register #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_mem_wb (
    .clk            (clk),
    .rst_n          (rst_n),
    .load           (wb_load),
    .bubble         (wb_bubble),
    .valid_d        (1'b1),
    .reg_write_d    (d_rw),
    .memto_reg_d    (d_m2r),
    .write_address_d(d_wa),
    .read_data_d    (d_rd),
    .aluresult_d    (d_alu),
    .wb_valid       (wb_valid),
    .reg_write      (RegWriteOut),
    .memto_reg      (MemtoRegOut),
    .write_address  (write_addressOut),
    .read_data      (read_dataOut),
    .aluresult      (aluresultOut)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected writebacks are queued at issue.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n, valid_in, Branch, MemRead, MemtoReg, MemWrite, RegWrite, zero;
  logic [4:0]  write_address;
  logic [31:0] aluresult, read_out2, incinst, dmem_rdata;
  logic        dmem_ack;
  logic        stall, pc_src, dmem_req, dmem_we, wb_valid, RegWriteOut, MemtoRegOut, mem_err;
  logic [31:0] branch_target, dmem_addr, dmem_wdata, read_dataOut, aluresultOut;
  logic [4:0]  write_addressOut;

  typedef struct packed {
    logic        rw;
    logic        m2r;
    logic [4:0]  wa;
    logic [31:0] rd;
    logic [31:0] alu;
  } wb_t;

  wb_t exp_q[$];
  wb_t exp_wb;
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .Branch(Branch), .MemRead(MemRead),
    .MemtoReg(MemtoReg), .MemWrite(MemWrite), .RegWrite(RegWrite), .zero(zero),
    .write_address(write_address), .aluresult(aluresult), .read_out2(read_out2),
    .incinst(incinst), .stall(stall), .pc_src(pc_src), .branch_target(branch_target),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .wb_valid(wb_valid),
    .RegWriteOut(RegWriteOut), .MemtoRegOut(MemtoRegOut), .write_addressOut(write_addressOut),
    .read_dataOut(read_dataOut), .aluresultOut(aluresultOut), .mem_err(mem_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    valid_in = 0; Branch = 0; MemRead = 0; MemtoReg = 0; MemWrite = 0; RegWrite = 0; zero = 0;
    write_address = '0; aluresult = '0; read_out2 = '0; incinst = '0;
    dmem_rdata = '0; dmem_ack = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    #1;
    checks++;
    if ((|{dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid, RegWriteOut, MemtoRegOut,
           write_addressOut, read_dataOut, aluresultOut, mem_err}) !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h wb_valid=%b rw=%b err=%b, want all 0",
               dmem_req, dmem_we, dmem_addr, wb_valid, RegWriteOut, mem_err);
    end
    checks++;
    if ({stall, pc_src} !== 2'b00) begin
      errors++;
      $display("FAIL reset_stall_pc: got stall=%b pc_src=%b, want 0 0", stall, pc_src);
    end
  endtask

  task automatic test_passthrough();
    valid_in = 1; RegWrite = 1; aluresult = 32'h42; write_address = 5'd5;
    exp_q.push_back('{rw: 1'b1, m2r: 1'b0, wa: 5'd5, rd: 32'h0, alu: 32'h42});
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL passthrough_stall: got %b want 0", stall);
    end
    tick();
    clear_inputs();
    #1;
    exp_wb = exp_q.pop_front();
    checks++;
    if (wb_valid !== 1'b1 ||
        {RegWriteOut, MemtoRegOut, write_addressOut, read_dataOut, aluresultOut} !== exp_wb) begin
      errors++;
      $display("FAIL passthrough_wb: got v=%b rw=%b wa=%0d alu=%h, want v=1 rw=%b wa=%0d alu=%h",
               wb_valid, RegWriteOut, write_addressOut, aluresultOut, exp_wb.rw, exp_wb.wa, exp_wb.alu);
    end
    $display("passthrough: alu=%h wa=%0d", aluresultOut, write_addressOut);
    tick();
    checks++;
    if (wb_valid !== 1'b0 || RegWriteOut !== 1'b0) begin
      errors++; $display("FAIL idle_bubble: got v=%b rw=%b want 0 0", wb_valid, RegWriteOut);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      valid_in = 1; RegWrite = $urandom_range(0, 1); MemtoReg = $urandom_range(0, 1);
      write_address = 5'($urandom); aluresult = $urandom;
      exp_q.push_back('{rw: RegWrite, m2r: MemtoReg, wa: write_address, rd: 32'h0, alu: aluresult});
      tick();
      exp_wb = exp_q.pop_front();
      checks++;
      if (wb_valid !== 1'b1 ||
          {RegWriteOut, MemtoRegOut, write_addressOut, read_dataOut, aluresultOut} !== exp_wb) begin
        errors++;
        $display("FAIL b2b_wb[%0d]: got v=%b rw=%b m2r=%b wa=%0d alu=%h, want rw=%b m2r=%b wa=%0d alu=%h",
                 i, wb_valid, RegWriteOut, MemtoRegOut, write_addressOut, aluresultOut,
                 exp_wb.rw, exp_wb.m2r, exp_wb.wa, exp_wb.alu);
      end
      $display("b2b[%0d]: alu=%h wa=%0d", i, aluresultOut, write_addressOut);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_branch();
    valid_in = 1; Branch = 1; zero = 1; incinst = 32'h40;
    #1;
    checks++;
    if (pc_src !== 1'b1 || branch_target !== 32'h40) begin
      errors++; $display("FAIL branch_taken: got pc_src=%b tgt=%h want 1 00000040", pc_src, branch_target);
    end
    zero = 0;
    #1;
    checks++;
    if (pc_src !== 1'b0) begin
      errors++; $display("FAIL branch_not_taken: got pc_src=%b want 0", pc_src);
    end
    $display("branch: target=%h", branch_target);
    clear_inputs();
    tick();
  endtask

  task automatic test_load();
    valid_in = 1; MemRead = 1; MemtoReg = 1; RegWrite = 1; write_address = 5'd8; aluresult = 32'h100;
    exp_q.push_back('{rw: 1'b1, m2r: 1'b1, wa: 5'd8, rd: 32'hDEADBEEF, alu: 32'h100});
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL load_accept_stall: got %b want 1", stall);
    end
    tick();
    checks++;
    if ({dmem_req, dmem_we, dmem_addr} !== {1'b1, 1'b0, 32'h100}) begin
      errors++; $display("FAIL load_req: got req=%b we=%b addr=%h want 1 0 00000100", dmem_req, dmem_we, dmem_addr);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (stall !== 1'b1 || wb_valid !== 1'b0) begin
        errors++; $display("FAIL load_wait[%0d]: got stall=%b v=%b want 1 0", k, stall, wb_valid);
      end
      tick();
    end
    dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL load_ack_stall: got %b want 0", stall);
    end
    tick();
    clear_inputs();
    #1;
    exp_wb = exp_q.pop_front();
    checks++;
    if (wb_valid !== 1'b1 || dmem_req !== 1'b0 ||
        {RegWriteOut, MemtoRegOut, write_addressOut, read_dataOut, aluresultOut} !== exp_wb) begin
      errors++;
      $display("FAIL load_wb: got v=%b req=%b m2r=%b rd=%h alu=%h, want v=1 req=0 m2r=1 rd=%h alu=%h",
               wb_valid, dmem_req, MemtoRegOut, read_dataOut, aluresultOut, exp_wb.rd, exp_wb.alu);
    end
    $display("load: addr=100 rdata=%h", read_dataOut);
  endtask

  task automatic test_store();
    valid_in = 1; MemWrite = 1; aluresult = 32'h200; read_out2 = 32'h1234; write_address = 5'd2;
    exp_q.push_back('{rw: 1'b0, m2r: 1'b0, wa: 5'd2, rd: 32'h0, alu: 32'h200});
    tick();
    checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== {1'b1, 1'b1, 32'h200, 32'h1234}) begin
      errors++;
      $display("FAIL store_req: got req=%b we=%b addr=%h wdata=%h want 1 1 00000200 00001234",
               dmem_req, dmem_we, dmem_addr, dmem_wdata);
    end
    dmem_ack = 1; dmem_rdata = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL store_ack_stall: got %b want 0", stall);
    end
    tick();
    clear_inputs();
    #1;
    exp_wb = exp_q.pop_front();
    checks++;
    if (wb_valid !== 1'b1 || dmem_req !== 1'b0 || mem_err !== 1'b0 ||
        {RegWriteOut, MemtoRegOut, write_addressOut, read_dataOut, aluresultOut} !== exp_wb) begin
      errors++;
      $display("FAIL store_wb: got v=%b req=%b err=%b rd=%h alu=%h, want v=1 req=0 err=0 rd=%h alu=%h",
               wb_valid, dmem_req, mem_err, read_dataOut, aluresultOut, exp_wb.rd, exp_wb.alu);
    end
    $display("store: addr=200 wdata=1234 rd=%h", read_dataOut);
  endtask

  task automatic test_timeout();
    int n = 0;
    valid_in = 1; MemRead = 1; MemtoReg = 1; RegWrite = 1; write_address = 5'd9; aluresult = 32'h300;
    exp_q.push_back('{rw: 1'b0, m2r: 1'b1, wa: 5'd9, rd: 32'h0, alu: 32'h300});
    tick();
    Branch = 1; zero = 1;
    #1;
    checks++;
    if (pc_src !== 1'b0) begin
      errors++; $display("FAIL pc_src_in_wait: got %b want 0", pc_src);
    end
    while (dmem_req === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    clear_inputs();
    #1;
    checks++;
    if (n !== 15) begin
      errors++; $display("FAIL timeout_cycles: got %0d WAIT cycles want 15", n);
    end
    exp_wb = exp_q.pop_front();
    checks++;
    if (wb_valid !== 1'b1 || mem_err !== 1'b1 ||
        {RegWriteOut, MemtoRegOut, write_addressOut, read_dataOut, aluresultOut} !== exp_wb) begin
      errors++;
      $display("FAIL timeout_wb: got v=%b err=%b rw=%b wa=%0d alu=%h, want v=1 err=1 rw=0 wa=%0d alu=%h",
               wb_valid, mem_err, RegWriteOut, write_addressOut, aluresultOut, exp_wb.wa, exp_wb.alu);
    end
    $display("timeout: wait_cycles=%0d mem_err=%b", n, mem_err);
    tick();
  endtask

  task automatic test_reset_mid_wait();
    valid_in = 1; MemRead = 1; RegWrite = 1; write_address = 5'd4; aluresult = 32'h400;
    tick(); tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    clear_inputs();
    #1;
    checks++;
    if ((|{dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid, RegWriteOut, MemtoRegOut,
           write_addressOut, read_dataOut, aluresultOut, mem_err}) !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_wait: got req=%b addr=%h v=%b err=%b want all 0",
               dmem_req, dmem_addr, wb_valid, mem_err);
    end
    dmem_ack = 1; dmem_rdata = 32'hCAFE_F00D;
    valid_in = 1; Branch = 1; zero = 1;
    #1;
    checks++;
    if (pc_src !== 1'b1) begin
      errors++; $display("FAIL reset_idle_state: got pc_src=%b want 1", pc_src);
    end
    valid_in = 0; Branch = 0; zero = 0;
    tick();
    clear_inputs();
    #1;
    checks++;
    if (wb_valid !== 1'b0 || dmem_req !== 1'b0 || read_dataOut !== 32'h0) begin
      errors++;
      $display("FAIL late_ack_ignored: got v=%b req=%b rd=%h want 0 0 0", wb_valid, dmem_req, read_dataOut);
    end
    $display("reset_mid_wait: req=%b v=%b", dmem_req, wb_valid);
  endtask

  task automatic test_misaligned();
    valid_in = 1; MemRead = 1; MemtoReg = 1; RegWrite = 1; write_address = 5'd3; aluresult = 32'h102;
    exp_q.push_back('{rw: 1'b0, m2r: 1'b1, wa: 5'd3, rd: 32'h0, alu: 32'h102});
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL misaligned_stall: got %b want 0", stall);
    end
    tick();
    clear_inputs();
    #1;
    exp_wb = exp_q.pop_front();
    checks++;
    if (wb_valid !== 1'b1 || mem_err !== 1'b1 || dmem_req !== 1'b0 ||
        {RegWriteOut, MemtoRegOut, write_addressOut, read_dataOut, aluresultOut} !== exp_wb) begin
      errors++;
      $display("FAIL misaligned_wb: got v=%b err=%b req=%b rw=%b alu=%h, want v=1 err=1 req=0 rw=0 alu=%h",
               wb_valid, mem_err, dmem_req, RegWriteOut, aluresultOut, exp_wb.alu);
    end
    tick();
    checks++;
    if (dmem_req !== 1'b0 || mem_err !== 1'b1) begin
      errors++; $display("FAIL misaligned_after: got req=%b err=%b want 0 1", dmem_req, mem_err);
    end
    $display("misaligned: addr=102 mem_err=%b", mem_err);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    test_reset();
    test_passthrough();
    test_back_to_back();
    test_branch();
    test_load();
    test_store();
    test_timeout();
    test_reset_mid_wait();
    test_misaligned();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
